pipe_skid_reg: RTL and testbench

- Parametrised IF/ID-class pipeline stage register for the 8-bit core; successor to the fixed enable/flush stage register.
- Carries a PC field, an instruction field and a generic sideband field (immediate/operand bytes) from one stage to the next.
- Replaces the plain enable with a valid/ready handshake and an optional skid entry, so upstream ready is registered and no data is lost under back-pressure.
- Flush injects a NOP bubble that keeps the PC.

---
 rtl/core_pipe_pkg.sv | 19 +
 rtl/pipe_skid_reg_if.sv | 37 +++
 rtl/pipe_stage_word.sv | 51 +++++
 rtl/pipe_skid_reg.sv | 174 +++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared constants for the 8-bit core pipeline stage registers.
//   - default field widths (PC, instruction, sideband)
//   - NOP opcode inserted on flush
//   - stage-state encoding used by pipe_skid_reg
package core_pipe_pkg;

  localparam int unsigned CORE_PC_W    = 8;
  localparam int unsigned CORE_INSTR_W = 8;
  localparam int unsigned CORE_SIDE_W  = 16;

  localparam logic [7:0] CORE_NOP = 8'h00;

  // Stage occupancy: EMPTY = M invalid, BUSY = M valid / S empty,
  // FULL = M and S both valid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle for one pipeline stage.
//   Upstream side : in_valid, in_ready, in_pc, in_instr, in_side
//   Downstream    : out_valid, out_ready, out_pc, out_instr, out_side, out_bubble
//   slave  modport: the stage register itself
//   master modport: whoever drives the upstream word and consumes the output
interface pipe_skid_reg_if
  import core_pipe_pkg::*;
#(
  parameter int unsigned PC_W    = CORE_PC_W,
  parameter int unsigned INSTR_W = CORE_INSTR_W,
  parameter int unsigned SIDE_W  = CORE_SIDE_W
) ();

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic [SIDE_W-1:0]  in_side;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [SIDE_W-1:0]  out_side;
  logic               out_bubble;

  modport slave (
    input  in_valid, in_pc, in_instr, in_side, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_side, out_bubble
  );

  modport master (
    output in_valid, in_pc, in_instr, in_side, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_side, out_bubble
  );

endinterface

// File: rtl/pipe_stage_word.sv
// pipe_stage_word: load-enabled register for one pipeline word
// (pc / instr / side / bubble flag). Synchronous active-high reset to zero.
//   clk, rst                : clock, synchronous reset
//   i_load                  : capture i_* on the rising edge
//   i_pc/i_instr/i_side/i_bubble : word to capture
//   o_pc/o_instr/o_side/o_bubble : held word
module pipe_stage_word
  import core_pipe_pkg::*;
#(
  parameter int unsigned PC_W    = CORE_PC_W,
  parameter int unsigned INSTR_W = CORE_INSTR_W,
  parameter int unsigned SIDE_W  = CORE_SIDE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [SIDE_W-1:0]  i_side,
  input  logic               i_bubble,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [SIDE_W-1:0]  o_side,
  output logic               o_bubble
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [SIDE_W-1:0]  r_side;
  logic               r_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_side   <= '0;
      r_bubble <= 1'b0;
    end else if (i_load) begin
      r_pc     <= i_pc;
      r_instr  <= i_instr;
      r_side   <= i_side;
      r_bubble <= i_bubble;
    end
  end

  assign o_pc     = r_pc;
  assign o_instr  = r_instr;
  assign o_side   = r_side;
  assign o_bubble = r_bubble;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: IF/ID-class pipeline stage register with valid/ready
// handshake, optional two-entry skid buffer and flush-to-bubble.
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset (overrides flush and handshakes)
//   flush : squash stage contents, insert a NOP bubble keeping the PC
//   bus   : handshake bundle (slave view), see pipe_skid_reg_if
// SKID=1: main reg M plus skid reg S, in_ready registered.
// SKID=0: M only, in_ready = !out_valid | out_ready.
module pipe_skid_reg
  import core_pipe_pkg::*;
#(
  parameter int unsigned PC_W      = CORE_PC_W,
  parameter int unsigned INSTR_W   = CORE_INSTR_W,
  parameter int unsigned SIDE_W    = CORE_SIDE_W,
  parameter logic [31:0] NOP_INSTR = 32'(CORE_NOP),
  parameter bit          SKID      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_skid_reg_if.slave  bus
);

  localparam logic [INSTR_W-1:0] LP_NOP = INSTR_W'(NOP_INSTR);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_out_valid;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_emit;

  logic               w_m_load;
  logic [PC_W-1:0]    w_m_pc_d,    w_m_pc_q;
  logic [INSTR_W-1:0] w_m_instr_d, w_m_instr_q;
  logic [SIDE_W-1:0]  w_m_side_d,  w_m_side_q;
  logic               w_m_bub_d,   w_m_bub_q;

  logic [PC_W-1:0]    w_s_pc_q;
  logic [INSTR_W-1:0] w_s_instr_q;
  logic [SIDE_W-1:0]  w_s_side_q;
  logic               w_s_bub_q;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_emit      = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_m_load    = 1'b0;
    w_m_pc_d    = bus.in_pc;
    w_m_instr_d = bus.in_instr;
    w_m_side_d  = bus.in_side;
    w_m_bub_d   = 1'b0;
    if (flush) begin
      // Bubble keeps the sideband of whatever M held and takes the incoming
      // PC only when a word is actually presented.
      w_m_load    = 1'b1;
      w_m_pc_d    = bus.in_valid ? bus.in_pc : w_m_pc_q;
      w_m_instr_d = LP_NOP;
      w_m_side_d  = w_m_side_q;
      w_m_bub_d   = 1'b1;
      w_state_nxt = ST_BUSY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_m_load    = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // With SKID=0, accept implies emit, so the FULL transition is
          // unreachable there.
          if (w_accept && w_emit) begin
            w_m_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            w_m_load    = 1'b1;
            w_m_pc_d    = w_s_pc_q;
            w_m_instr_d = w_s_instr_q;
            w_m_side_d  = w_s_side_q;
            w_m_bub_d   = w_s_bub_q;
            w_state_nxt = ST_BUSY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  pipe_stage_word #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .SIDE_W  (SIDE_W)
  ) u_m (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_m_load),
    .i_pc     (w_m_pc_d),
    .i_instr  (w_m_instr_d),
    .i_side   (w_m_side_d),
    .i_bubble (w_m_bub_d),
    .o_pc     (w_m_pc_q),
    .o_instr  (w_m_instr_q),
    .o_side   (w_m_side_q),
    .o_bubble (w_m_bub_q)
  );

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;
      logic w_s_load;

      assign w_s_load = !flush && (r_state == ST_BUSY) && w_accept && !w_emit;

      // Registered ready: deasserted exactly when the next state is FULL.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_FULL);
        end
      end
      assign w_in_ready = r_in_ready;

      pipe_stage_word #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .SIDE_W  (SIDE_W)
      ) u_s (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_s_load),
        .i_pc     (bus.in_pc),
        .i_instr  (bus.in_instr),
        .i_side   (bus.in_side),
        .i_bubble (1'b0),
        .o_pc     (w_s_pc_q),
        .o_instr  (w_s_instr_q),
        .o_side   (w_s_side_q),
        .o_bubble (w_s_bub_q)
      );
    end else begin : g_noskid
      assign w_in_ready  = !w_out_valid | bus.out_ready;
      assign w_s_pc_q    = '0;
      assign w_s_instr_q = '0;
      assign w_s_side_q  = '0;
      assign w_s_bub_q   = 1'b0;
    end
  endgenerate

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_pc     = w_m_pc_q;
  assign bus.out_instr  = w_m_instr_q;
  assign bus.out_side   = w_m_side_q;
  assign bus.out_bubble = w_m_bub_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed bench for pipe_skid_reg, table of per-cycle
// vectors for SKID=1 and a hand sequence for SKID=0 combinational ready.
module tb_pipe_skid_reg;

  typedef struct {
    logic        rst, flush, iv;
    logic [7:0]  pc, instr;
    logic [15:0] side;
    logic        ordy;
    logic        e_ov, e_ir;
    logic [7:0]  e_pc, e_instr;
    logic [15:0] e_side;
    logic        e_bub;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.PC_W(8), .INSTR_W(8), .SIDE_W(16)) bus1 ();
  pipe_skid_reg_if #(.PC_W(8), .INSTR_W(8), .SIDE_W(16)) bus0 ();

  pipe_skid_reg #(.PC_W(8), .INSTR_W(8), .SIDE_W(16), .NOP_INSTR(32'h0), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1)
  );

  pipe_skid_reg #(.PC_W(8), .INSTR_W(8), .SIDE_W(16), .NOP_INSTR(32'h0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0)
  );

  function automatic vec_t mk(input logic r, f, v, input logic [7:0] p, i, input logic [15:0] s,
                              input logic o, eov, eir, input logic [7:0] ep, ei,
                              input logic [15:0] es, input logic eb);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.pc = p; t.instr = i; t.side = s; t.ordy = o;
    t.e_ov = eov; t.e_ir = eir; t.e_pc = ep; t.e_instr = ei; t.e_side = es; t.e_bub = eb;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    bus1.in_valid = 0; bus1.in_pc = 0; bus1.in_instr = 0; bus1.in_side = 0; bus1.out_ready = 1;
    bus0.in_valid = 0; bus0.in_pc = 0; bus0.in_instr = 0; bus0.in_side = 0; bus0.out_ready = 1;

    // reset, reset+flush, idle
    tbl.push_back(mk(1,1,1,8'h09,8'h99,16'h9999,1, 0,1,8'h00,8'h00,16'h0000,0));
    tbl.push_back(mk(1,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h00,8'h00,16'h0000,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h00,8'h00,16'h0000,0));
    // streaming 11..14
    tbl.push_back(mk(0,0,1,8'h01,8'h11,16'h0111,1, 1,1,8'h01,8'h11,16'h0111,0));
    tbl.push_back(mk(0,0,1,8'h02,8'h12,16'h0212,1, 1,1,8'h02,8'h12,16'h0212,0));
    tbl.push_back(mk(0,0,1,8'h03,8'h13,16'h0313,1, 1,1,8'h03,8'h13,16'h0313,0));
    tbl.push_back(mk(0,0,1,8'h04,8'h14,16'h0414,1, 1,1,8'h04,8'h14,16'h0414,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h04,8'h14,16'h0414,0));
    // back-pressure: A1, A2 into skid, A3 refused, drain
    tbl.push_back(mk(0,0,1,8'h10,8'hA1,16'hA1A1,0, 1,1,8'h10,8'hA1,16'hA1A1,0));
    tbl.push_back(mk(0,0,1,8'h11,8'hA2,16'hA2A2,0, 1,0,8'h10,8'hA1,16'hA1A1,0));
    tbl.push_back(mk(0,0,1,8'h12,8'hA3,16'hA3A3,0, 1,0,8'h10,8'hA1,16'hA1A1,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,1, 1,1,8'h11,8'hA2,16'hA2A2,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h11,8'hA2,16'hA2A2,0));
    // fill to FULL, then flush with in_valid, pc 37
    tbl.push_back(mk(0,0,1,8'h20,8'hB1,16'hB1B1,0, 1,1,8'h20,8'hB1,16'hB1B1,0));
    tbl.push_back(mk(0,0,1,8'h21,8'hB2,16'hB2B2,0, 1,0,8'h20,8'hB1,16'hB1B1,0));
    tbl.push_back(mk(0,1,1,8'h37,8'h55,16'h5555,0, 1,1,8'h37,8'h00,16'hB1B1,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,0, 1,1,8'h37,8'h00,16'hB1B1,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h37,8'h00,16'hB1B1,1));
    // flush without in_valid keeps pc 05; back-to-back flush; then 22 clears bubble
    tbl.push_back(mk(0,0,1,8'h05,8'h33,16'h0533,0, 1,1,8'h05,8'h33,16'h0533,0));
    tbl.push_back(mk(0,1,0,8'h00,8'h00,16'h0000,0, 1,1,8'h05,8'h00,16'h0533,1));
    tbl.push_back(mk(0,1,0,8'h00,8'h00,16'h0000,0, 1,1,8'h05,8'h00,16'h0533,1));
    tbl.push_back(mk(0,0,1,8'h06,8'h22,16'h0622,1, 1,1,8'h06,8'h22,16'h0622,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h06,8'h22,16'h0622,0));
    // flush from EMPTY, then reset
    tbl.push_back(mk(0,1,1,8'h40,8'h77,16'h7777,1, 1,1,8'h40,8'h00,16'h0622,1));
    tbl.push_back(mk(1,0,0,8'h00,8'h00,16'h0000,1, 0,1,8'h00,8'h00,16'h0000,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush;
      bus1.in_valid = tbl[i].iv; bus1.in_pc = tbl[i].pc; bus1.in_instr = tbl[i].instr;
      bus1.in_side = tbl[i].side; bus1.out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 16'(bus1.out_valid), 16'(tbl[i].e_ov));
      chk($sformatf("v%0d in_ready", i), 16'(bus1.in_ready), 16'(tbl[i].e_ir));
      chk($sformatf("v%0d out_pc", i), 16'(bus1.out_pc), 16'(tbl[i].e_pc));
      chk($sformatf("v%0d out_instr", i), 16'(bus1.out_instr), 16'(tbl[i].e_instr));
      chk($sformatf("v%0d out_side", i), bus1.out_side, tbl[i].e_side);
      chk($sformatf("v%0d out_bubble", i), 16'(bus1.out_bubble), 16'(tbl[i].e_bub));
    end

    // SKID=0: combinational in_ready
    rst = 1; flush = 0; bus1.in_valid = 0;
    bus0.in_valid = 0; bus0.out_ready = 0;
    @(posedge clk); #1;
    chk("s0 reset out_valid", 16'(bus0.out_valid), 16'h0);
    chk("s0 reset in_ready", 16'(bus0.in_ready), 16'h1);
    rst = 0;
    bus0.in_valid = 1; bus0.in_pc = 8'h01; bus0.in_instr = 8'hC1; bus0.in_side = 16'h01C1;
    bus0.out_ready = 0;
    @(posedge clk); #1;
    chk("s0 C1 out_valid", 16'(bus0.out_valid), 16'h1);
    chk("s0 C1 out_instr", 16'(bus0.out_instr), 16'h00C1);
    chk("s0 stall in_ready", 16'(bus0.in_ready), 16'h0);
    bus0.in_valid = 0; bus0.out_ready = 1; #1;
    chk("s0 ready comb", 16'(bus0.in_ready), 16'h1);
    bus0.in_valid = 1; bus0.in_pc = 8'h02; bus0.in_instr = 8'hC2; bus0.in_side = 16'h02C2;
    @(posedge clk); #1;
    chk("s0 C2 out_instr", 16'(bus0.out_instr), 16'h00C2);
    chk("s0 C2 out_pc", 16'(bus0.out_pc), 16'h0002);
    chk("s0 C2 in_ready", 16'(bus0.in_ready), 16'h1);
    bus0.in_valid = 0; bus0.out_ready = 0; #1;
    chk("s0 drop in_ready", 16'(bus0.in_ready), 16'h0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("s0 flush instr", 16'(bus0.out_instr), 16'h0000);
    chk("s0 flush pc", 16'(bus0.out_pc), 16'h0002);
    chk("s0 flush bubble", 16'(bus0.out_bubble), 16'h1);
    chk("s0 flush side", bus0.out_side, 16'h02C2);
    bus0.out_ready = 1;
    @(posedge clk); #1;
    chk("s0 drain out_valid", 16'(bus0.out_valid), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
